// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: word handshake and completion signals between the sequencer and the SPI master
interface spi_master_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_dc;
  logic                  i_tx_last;
  logic                  i_tx_valid;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_done;
  logic                  o_busy;
  modport slave (input i_tx_data, i_tx_dc, i_tx_last, i_tx_valid, output o_tx_ready, o_rx_data, o_done, o_busy);
  modport master (output i_tx_data, i_tx_dc, i_tx_last, i_tx_valid, input o_tx_ready, o_rx_data, o_done, o_busy);
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: full-duplex SPI master, all CPOL/CPHA modes, selectable bit order, bursts with D/C flag
module spi_master_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLK_DIV        = 2,
  parameter bit CPOL           = 0,
  parameter bit CPHA           = 0,
  parameter bit MSB_FIRST      = 1,
  parameter int SS_IDLE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  spi_master_ctrl_if.slave bus,
  input  logic             i_miso,
  output logic             o_mosi,
  output logic             o_s_clk,
  output logic             o_ss,
  output logic             o_dc
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(2 * DATA_WIDTH + 1);
  // the accepting IDLE cycle completes the o_ss-high interval between bursts
  localparam int GAP_N = (SS_IDLE_CYCLES > 1) ? SS_IDLE_CYCLES - 1 : 1;
  localparam int GW = $clog2(GAP_N + 1);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, TAIL, GAP} state_t;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit, w_j;
  logic [GW-1:0]         r_gap;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rx_data, w_rx_sh;
  logic                  r_mosi, r_sclk, r_dc, r_last, r_done;
  logic                  w_rdy, w_acc, w_hp_end, w_last_edge, w_xfer_end, w_edge, w_lead, w_samp, w_shift;
  function automatic logic [DATA_WIDTH-1:0] f_shl(input logic [DATA_WIDTH-1:0] x);
    return MSB_FIRST ? x << 1 : x >> 1;
  endfunction
  function automatic logic f_head(input logic [DATA_WIDTH-1:0] x);
    return MSB_FIRST ? x[DATA_WIDTH-1] : x[0];
  endfunction
  assign w_rdy          = i_rst_n && (r_state == IDLE || r_state == WAIT);
  assign w_acc          = bus.i_tx_valid && w_rdy;
  assign bus.o_tx_ready = w_rdy;
  assign bus.o_busy     = r_state != IDLE;
  assign bus.o_done     = r_done;
  assign bus.o_rx_data  = r_rx_data;
  assign o_ss           = r_state inside {IDLE, GAP};
  assign o_mosi         = r_mosi;
  assign o_s_clk        = r_sclk;
  assign o_dc           = r_dc;
  assign w_hp_end    = r_cnt == CW'(CLK_DIV - 1);
  assign w_last_edge = r_bit == BW'(2 * DATA_WIDTH - 1);
  assign w_xfer_end  = r_state == XFER && w_hp_end && w_last_edge;
  // edge j opens half-period j; even j is the leading edge
  assign w_edge  = w_hp_end && (r_state == SETUP || (r_state == XFER && !w_last_edge));
  assign w_j     = (r_state == XFER) ? r_bit + BW'(1) : '0;
  assign w_lead  = !w_j[0];
  assign w_samp  = w_edge && (w_lead ^ CPHA);
  assign w_shift = w_edge && (CPHA ? w_lead : (!w_lead && w_j != BW'(2 * DATA_WIDTH - 1)));
  assign w_rx_sh = MSB_FIRST ? ((r_rx << 1) | DATA_WIDTH'(i_miso))
                             : ((r_rx >> 1) | (DATA_WIDTH'(i_miso) << (DATA_WIDTH - 1)));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, WAIT: w_next = w_acc ? SETUP : r_state;
      SETUP:      w_next = w_hp_end ? XFER : SETUP;
      XFER:       w_next = w_xfer_end ? (r_last ? TAIL : WAIT) : XFER;
      TAIL:       w_next = w_hp_end ? GAP : TAIL;
      GAP:        w_next = (r_gap == GW'(GAP_N - 1)) ? IDLE : GAP;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_mosi    <= 1'b0;
      r_sclk    <= CPOL;
      r_dc      <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cnt  <= (r_state inside {SETUP, XFER, TAIL} && !w_hp_end) ? r_cnt + CW'(1) : '0;
      r_bit  <= (r_state != XFER || w_xfer_end) ? '0 : w_hp_end ? r_bit + BW'(1) : r_bit;
      r_gap  <= (r_state == GAP && w_next == GAP) ? r_gap + GW'(1) : '0;
      r_sclk <= r_sclk ^ w_edge;
      r_done <= w_xfer_end;
      if (w_xfer_end) r_rx_data <= r_rx;
      if (w_samp) r_rx <= w_rx_sh;
      if (w_acc) begin
        r_tx   <= CPHA ? bus.i_tx_data : f_shl(bus.i_tx_data);
        r_dc   <= bus.i_tx_dc;
        r_last <= bus.i_tx_last;
        if (!CPHA) r_mosi <= f_head(bus.i_tx_data);
      end else if (w_shift) begin
        r_tx   <= f_shl(r_tx);
        r_mosi <= f_head(r_tx);
      end
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: mode-0 MSB-first and mode-3 LSB-first masters against a loopback slave and a word-level model
module tb_spi_master_ctrl;
  localparam int DW = 8, CD = 2, SSI = 4;
  localparam int LOWT = (2 * DW + 2) * CD;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] valid = '0, tdc = '0, tlast = '0, inv = '0;
  logic [DW-1:0] tdat [2];
  wire [1:0] ready, done, busy, ss, sclk, mosi, dcw, miso;
  wire [DW-1:0] rxd [2];
  int vec = 0, miss = 0;
  bit mq [2][$];
  bit dq [2][$];
  logic [DW-1:0] rq [2][$];
  int rise [2], dn [2], falls [2], lowr [2], lastlow [2], highr [2], lasthigh [2];
  logic psclk [2], pss [2];
  logic [DW-1:0] bw [8];
  logic bc [8];
  int bn;

  spi_master_ctrl_if #(.DATA_WIDTH(DW)) b0 ();
  spi_master_ctrl_if #(.DATA_WIDTH(DW)) b3 ();
  assign b0.i_tx_data = tdat[0];
  assign b0.i_tx_dc = tdc[0];
  assign b0.i_tx_last = tlast[0];
  assign b0.i_tx_valid = valid[0];
  assign b3.i_tx_data = tdat[1];
  assign b3.i_tx_dc = tdc[1];
  assign b3.i_tx_last = tlast[1];
  assign b3.i_tx_valid = valid[1];
  assign ready = {b3.o_tx_ready, b0.o_tx_ready};
  assign done = {b3.o_done, b0.o_done};
  assign busy = {b3.o_busy, b0.o_busy};
  assign rxd[0] = b0.o_rx_data;
  assign rxd[1] = b3.o_rx_data;
  assign miso = mosi ^ inv;

  spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SS_IDLE_CYCLES(SSI)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave), .i_miso(miso[0]),
    .o_mosi(mosi[0]), .o_s_clk(sclk[0]), .o_ss(ss[0]), .o_dc(dcw[0]));
  spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SS_IDLE_CYCLES(SSI)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b3.slave), .i_miso(miso[1]),
    .o_mosi(mosi[1]), .o_s_clk(sclk[1]), .o_ss(ss[1]), .o_dc(dcw[1]));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (sclk[k] === 1'b1 && psclk[k] === 1'b0) begin
        rise[k]++;
        mq[k].push_back(mosi[k]);
        dq[k].push_back(dcw[k]);
      end
      if (done[k] === 1'b1) begin
        dn[k]++;
        rq[k].push_back(rxd[k]);
      end
      if (ss[k] === 1'b0) begin
        if (pss[k] === 1'b1) begin
          falls[k]++;
          lasthigh[k] = highr[k];
        end
        highr[k] = 0;
        lowr[k]++;
      end else begin
        if (pss[k] === 1'b0) lastlow[k] = lowr[k];
        lowr[k] = 0;
        highr[k]++;
      end
      psclk[k] = sclk[k];
      pss[k] = ss[k];
    end
  end

  function automatic bit exp_bit(input int k, input int i);
    logic [DW-1:0] w;
    w = bw[i / DW];
    return (k == 0) ? w[DW - 1 - (i % DW)] : w[i % DW];
  endfunction
  function automatic logic [31:0] pack_m(input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < mq[k].size() && i < 32; i++) v = {v[30:0], mq[k][i]};
    return v;
  endfunction
  function automatic logic [31:0] exp_m(input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < DW * bn; i++) v = {v[30:0], exp_bit(k, i)};
    return v;
  endfunction
  function automatic logic [31:0] pack_d(input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < dq[k].size() && i < 32; i++) v = {v[30:0], dq[k][i]};
    return v;
  endfunction
  function automatic logic [31:0] exp_d();
    logic [31:0] v = '0;
    for (int i = 0; i < DW * bn; i++) v = {v[30:0], bc[i / DW]};
    return v;
  endfunction
  function automatic logic [31:0] pack_r(input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < rq[k].size() && i < 4; i++) v = {v[23:0], rq[k][i]};
    return v;
  endfunction
  function automatic logic [31:0] exp_r(input int k);
    logic [31:0] v = '0;
    for (int j = 0; j < bn; j++) v = {v[23:0], inv[k] ? ~bw[j] : bw[j]};
    return v;
  endfunction

  task automatic clr(input int k);
    mq[k].delete();
    dq[k].delete();
    rq[k].delete();
    rise[k] = 0;
    dn[k] = 0;
    falls[k] = 0;
  endtask

  task automatic put(input int k, input logic [DW-1:0] d, input logic c, input logic l, input bit hold);
    int n = 0;
    @(negedge clk);
    tdat[k] = d;
    tdc[k] = c;
    tlast[k] = l;
    valid[k] = 1'b1;
    while (ready[k] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      vec++;
      miss++;
      $display("FAIL put_timeout[%0d]: ready=%b after %0d cycles, required 1", k, ready[k], n);
    end
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      vec++;
      miss++;
      $display("FAIL idle_timeout[%0d]: busy=%b after %0d cycles, required 0", k, busy[k], n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_burst(input int k);
    clr(k);
    for (int j = 0; j < bn; j++) put(k, bw[j], bc[j], j == bn - 1, 1'b0);
    wait_idle(k);
  endtask

  task automatic test_reset();
    logic [6:0] g, e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      g = {ss[k], sclk[k], mosi[k], dcw[k], done[k], busy[k], ready[k]};
      e = {1'b1, (k == 1), 5'b00000};
      vec++;
      if (g !== e) begin
        miss++;
        $display("FAIL reset_outputs[%0d]: ss,sclk,mosi,dc,done,busy,ready=%b required %b", k, g, e);
      end
      vec++;
      if (rxd[k] !== '0) begin
        miss++;
        $display("FAIL reset_rx[%0d]: rx_data=%h required 00", k, rxd[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (ready !== 2'b11) begin
      miss++;
      $display("FAIL reset_release_ready: ready=%b required 11", ready);
    end
  endtask

  task automatic test_single();
    bn = 1;
    bw[0] = 8'hF1;
    bc[0] = 1'b0;
    inv[0] = 1'b0;
    clr(0);
    put(0, bw[0], 1'b0, 1'b1, 1'b0);
    vec++;
    if (ss[0] !== 1'b0) begin
      miss++;
      $display("FAIL ss_fall: ss=%b one cycle after accept, required 0", ss[0]);
    end
    wait_idle(0);
    vec++;
    if (rise[0] != 8 || dn[0] != 1) begin
      miss++;
      $display("FAIL single_counts: rising=%0d done=%0d, required 8 and 1", rise[0], dn[0]);
    end
    vec++;
    if (pack_m(0) !== 32'h0000_00F1) begin
      miss++;
      $display("FAIL single_mosi: bits=%h required 000000f1", pack_m(0));
    end
    vec++;
    if (lastlow[0] != LOWT) begin
      miss++;
      $display("FAIL single_ss_low: %0d cycles, required %0d", lastlow[0], LOWT);
    end
  endtask

  task automatic test_loopback();
    bn = 1;
    bw[0] = 8'h0E;
    bc[0] = 1'b1;
    inv[0] = 1'b0;
    run_burst(0);
    vec++;
    if (rq[0].size() != 1 || pack_r(0) !== 32'h0000_000E) begin
      miss++;
      $display("FAIL loopback_rx: %0d words %h, required 1 word 0000000e", rq[0].size(), pack_r(0));
    end
    vec++;
    if (rxd[0] !== 8'h0E) begin
      miss++;
      $display("FAIL loopback_hold: rx_data=%h after done, required 0e", rxd[0]);
    end
  endtask

  task automatic test_burst();
    int n = 0;
    bn = 2;
    bw[0] = 8'hA5;
    bc[0] = 1'b0;
    bw[1] = 8'h3C;
    bc[1] = 1'b1;
    inv[0] = 1'b0;
    clr(0);
    put(0, bw[0], bc[0], 1'b0, 1'b0);
    while (done[0] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if ({ready[0], ss[0]} !== 2'b10) begin
      miss++;
      $display("FAIL wait_ready: ready,ss=%b%b after first done, required 10", ready[0], ss[0]);
    end
    put(0, bw[1], bc[1], 1'b1, 1'b0);
    wait_idle(0);
    vec++;
    if (falls[0] != 1 || rise[0] != 16 || dn[0] != 2) begin
      miss++;
      $display("FAIL burst_counts: ss_falls=%0d rising=%0d done=%0d, required 1 16 2", falls[0], rise[0], dn[0]);
    end
    vec++;
    if (pack_m(0) !== exp_m(0)) begin
      miss++;
      $display("FAIL burst_mosi: bits=%h required %h", pack_m(0), exp_m(0));
    end
    vec++;
    if (pack_d(0) !== exp_d()) begin
      miss++;
      $display("FAIL burst_dc: dc per edge=%h required %h", pack_d(0), exp_d());
    end
    vec++;
    if (pack_r(0) !== exp_r(0)) begin
      miss++;
      $display("FAIL burst_rx: rx words=%h required %h", pack_r(0), exp_r(0));
    end
  endtask

  task automatic test_mode3();
    bn = 1;
    bw[0] = 8'hF1;
    bc[0] = 1'b1;
    inv[1] = 1'b0;
    run_burst(1);
    vec++;
    if (pack_m(1) !== 32'h0000_008F || rise[1] != 8) begin
      miss++;
      $display("FAIL mode3_mosi: bits=%h rising=%0d, required 0000008f and 8", pack_m(1), rise[1]);
    end
    vec++;
    if (sclk[1] !== 1'b1) begin
      miss++;
      $display("FAIL mode3_idle_clk: s_clk=%b required 1", sclk[1]);
    end
    vec++;
    if (pack_r(1) !== exp_r(1)) begin
      miss++;
      $display("FAIL mode3_rx: rx=%h required %h", pack_r(1), exp_r(1));
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int d0;
    bn = 1;
    bw[0] = 8'($urandom);
    bc[0] = 1'b0;
    inv[0] = 1'b0;
    clr(0);
    put(0, bw[0], 1'b0, 1'b1, 1'b0);
    while (rise[0] < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    d0 = dn[0];
    rst_n = 1'b0;
    @(negedge clk);
    vec++;
    if ({ss[0], sclk[0], busy[0], ready[0]} !== 4'b1000) begin
      miss++;
      $display("FAIL midreset_state: ss,sclk,busy,ready=%b%b%b%b required 1000", ss[0], sclk[0], busy[0], ready[0]);
    end
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    vec++;
    if (dn[0] != d0 || rxd[0] !== '0) begin
      miss++;
      $display("FAIL midreset_nodone: done pulses=%0d rx=%h, required %0d and 00", dn[0] - d0, rxd[0], 0);
    end
    bw[0] = 8'($urandom);
    run_burst(0);
    vec++;
    if (pack_m(0) !== exp_m(0) || pack_r(0) !== exp_r(0)) begin
      miss++;
      $display("FAIL midreset_next: mosi=%h rx=%h, required %h %h", pack_m(0), pack_r(0), exp_m(0), exp_r(0));
    end
  endtask

  task automatic test_back_to_back();
    bn = 2;
    bw[0] = 8'($urandom);
    bw[1] = 8'($urandom);
    bc[0] = 1'b0;
    bc[1] = 1'b0;
    inv[0] = 1'b0;
    clr(0);
    put(0, bw[0], 1'b0, 1'b1, 1'b1);
    tdat[0] = bw[1];
    put(0, bw[1], 1'b0, 1'b1, 1'b0);
    wait_idle(0);
    vec++;
    if (falls[0] != 2 || lasthigh[0] != SSI) begin
      miss++;
      $display("FAIL b2b_gap: ss_falls=%0d high=%0d cycles, required 2 and %0d", falls[0], lasthigh[0], SSI);
    end
    vec++;
    if (pack_m(0) !== exp_m(0) || pack_r(0) !== exp_r(0)) begin
      miss++;
      $display("FAIL b2b_data: mosi=%h rx=%h, required %h %h", pack_m(0), pack_r(0), exp_m(0), exp_r(0));
    end
  endtask

  task automatic test_random();
    int k;
    for (int it = 0; it < 12; it++) begin
      k = it % 2;
      bn = $urandom_range(1, 3);
      for (int j = 0; j < bn; j++) begin
        bw[j] = 8'($urandom);
        bc[j] = 1'($urandom);
      end
      inv[k] = 1'($urandom);
      run_burst(k);
      vec++;
      if (rise[k] != DW * bn || dn[k] != bn || falls[k] != 1) begin
        miss++;
        $display("FAIL rand_counts[%0d]: rising=%0d done=%0d falls=%0d, required %0d %0d 1", it, rise[k], dn[k], falls[k], DW * bn, bn);
      end
      vec++;
      if (pack_m(k) !== exp_m(k)) begin
        miss++;
        $display("FAIL rand_mosi[%0d]: bits=%h required %h", it, pack_m(k), exp_m(k));
      end
      vec++;
      if (pack_d(k) !== exp_d()) begin
        miss++;
        $display("FAIL rand_dc[%0d]: dc=%h required %h", it, pack_d(k), exp_d());
      end
      vec++;
      if (pack_r(k) !== exp_r(k)) begin
        miss++;
        $display("FAIL rand_rx[%0d]: rx=%h required %h", it, pack_r(k), exp_r(k));
      end
      if (bn == 1) begin
        vec++;
        if (lastlow[k] != LOWT) begin
          miss++;
          $display("FAIL rand_ss_low[%0d]: %0d cycles, required %0d", it, lastlow[k], LOWT);
        end
      end
    end
  endtask

  initial begin
    tdat[0] = '0;
    tdat[1] = '0;
    test_reset();
    test_single();
    test_loopback();
    test_burst();
    test_mode3();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
